r16_pipe_delay_bank: RTL and testbench

Parametrised pipeline-register bank for the radix-16 butterfly datapath. It carries a P_WIDTH data word and its carry bit through DATA_DEPTH stages, and a (P_WIDTH+1)-bit side operand (e.g. N^-1/2 constant) through an independent SIDE_DEPTH stages, so operands re-align at the next arithmetic stage. Compared with the fixed 1-/2-cycle register stages it replaces, it adds:
- valid tracking
- a global stall
- synchronous flush
- optional bubble zeroing
- a primed indicator for downstream start-up

---
 rtl/r16_pipe_delay_bank_if.sv | 27 ++
 rtl/r16_pipe_delay_bank.sv | 89 ++++++++
 tb/tb_r16_pipe_delay_bank.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/r16_pipe_delay_bank_if.sv
// Handshake/bus bundle for the radix-16 pipeline delay bank: qualified data/carry/side in, delayed copies out.
interface r16_pipe_delay_bank_if #(
    parameter int P_WIDTH = 64
);
    logic               stall;
    logic               flush;
    logic               valid_in;
    logic [P_WIDTH-1:0] data_in;
    logic               carry_in;
    logic [P_WIDTH:0]   side_in;
    logic [P_WIDTH-1:0] data_out;
    logic               carry_out;
    logic               valid_out;
    logic [P_WIDTH:0]   side_out;
    logic               side_valid_out;
    logic               primed;

    modport master (
        output stall, flush, valid_in, data_in, carry_in, side_in,
        input  data_out, carry_out, valid_out, side_out, side_valid_out, primed
    );

    modport slave (
        input  stall, flush, valid_in, data_in, carry_in, side_in,
        output data_out, carry_out, valid_out, side_out, side_valid_out, primed
    );
endinterface

// File: rtl/r16_pipe_delay_bank.sv
// Delay bank: data/carry/valid delayed DATA_DEPTH advances, side operand SIDE_DEPTH advances.
// Global stall freezes everything (inputs dropped); no internal back-pressure.
module r16_pipe_delay_bank #(
    parameter int P_WIDTH     = 64,
    parameter int DATA_DEPTH  = 1,
    parameter int SIDE_DEPTH  = 2,
    parameter bit ZERO_BUBBLE = 1'b0
) (
    input logic clk,
    input logic rst_n,
    r16_pipe_delay_bank_if.slave bus
);
    localparam int MAXD = (DATA_DEPTH > SIDE_DEPTH) ? DATA_DEPTH : SIDE_DEPTH;
    localparam int CW   = $clog2(MAXD + 1);

    typedef struct packed {
        logic               vld;
        logic               carry;
        logic [P_WIDTH-1:0] dat;
    } dstage_t;

    typedef struct packed {
        logic             vld;
        logic [P_WIDTH:0] dat;
    } sstage_t;

    dstage_t d_q   [DATA_DEPTH];
    dstage_t d_src [DATA_DEPTH];
    sstage_t s_q   [SIDE_DEPTH];
    sstage_t s_src [SIDE_DEPTH];

    logic [CW-1:0] cnt_q;
    logic          primed_q;

    // Next-stage values; bubbles optionally carry zero payload so stale data never leaks downstream.
    always_comb begin
        d_src[0] = '{vld: bus.valid_in, carry: bus.carry_in, dat: bus.data_in};
        for (int k = 1; k < DATA_DEPTH; k++) d_src[k] = d_q[k-1];
        s_src[0] = '{vld: bus.valid_in, dat: bus.side_in};
        for (int k = 1; k < SIDE_DEPTH; k++) s_src[k] = s_q[k-1];
        if (ZERO_BUBBLE) begin
            for (int k = 0; k < DATA_DEPTH; k++)
                if (!d_src[k].vld) d_src[k] = '0;
            for (int k = 0; k < SIDE_DEPTH; k++)
                if (!s_src[k].vld) s_src[k] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DATA_DEPTH; k++) d_q[k] <= '0;
        end else if (bus.flush) begin
            for (int k = 0; k < DATA_DEPTH; k++) d_q[k] <= '0;
        end else if (!bus.stall) begin
            for (int k = 0; k < DATA_DEPTH; k++) d_q[k] <= d_src[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SIDE_DEPTH; k++) s_q[k] <= '0;
        end else if (bus.flush) begin
            for (int k = 0; k < SIDE_DEPTH; k++) s_q[k] <= '0;
        end else if (!bus.stall) begin
            for (int k = 0; k < SIDE_DEPTH; k++) s_q[k] <= s_src[k];
        end
    end

    // Counts advances (not valid words) so primed means every stage has been written since clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            primed_q <= 1'b0;
        end else if (bus.flush) begin
            cnt_q    <= '0;
            primed_q <= 1'b0;
        end else if (!bus.stall && (cnt_q != CW'(MAXD))) begin
            cnt_q    <= cnt_q + 1'b1;
            primed_q <= (cnt_q == CW'(MAXD - 1));
        end
    end

    assign bus.data_out       = d_q[DATA_DEPTH-1].dat;
    assign bus.carry_out      = d_q[DATA_DEPTH-1].carry;
    assign bus.valid_out      = d_q[DATA_DEPTH-1].vld;
    assign bus.side_out       = s_q[SIDE_DEPTH-1].dat;
    assign bus.side_valid_out = s_q[SIDE_DEPTH-1].vld;
    assign bus.primed         = primed_q;
endmodule

// File: tb/tb_r16_pipe_delay_bank.sv
// Directed vector table on the default bank, hand sequences for stall/reset/flush/bubbles, and a depth sweep scoreboard.
module tb_r16_pipe_delay_bank;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        vin = 1'b0;
    logic        cin = 1'b0;
    logic [63:0] din = '0;
    logic [64:0] sin = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    r16_pipe_delay_bank_if #(.P_WIDTH(64)) if_def ();
    r16_pipe_delay_bank_if #(.P_WIDTH(64)) if_fl ();

    assign if_def.stall = stall;
    assign if_def.flush = flush;
    assign if_def.valid_in = vin;
    assign if_def.data_in = din;
    assign if_def.carry_in = cin;
    assign if_def.side_in = sin;
    assign if_fl.stall = stall;
    assign if_fl.flush = flush;
    assign if_fl.valid_in = vin;
    assign if_fl.data_in = din;
    assign if_fl.carry_in = cin;
    assign if_fl.side_in = sin;

    r16_pipe_delay_bank #(.P_WIDTH(64), .DATA_DEPTH(1), .SIDE_DEPTH(2), .ZERO_BUBBLE(1'b0))
        u_def (.clk(clk), .rst_n(rst_n), .bus(if_def));
    r16_pipe_delay_bank #(.P_WIDTH(64), .DATA_DEPTH(4), .SIDE_DEPTH(6), .ZERO_BUBBLE(1'b1))
        u_fl (.clk(clk), .rst_n(rst_n), .bus(if_fl));

    logic [17:0] sw_d [1:8][1:8];
    logic [17:0] sw_s [1:8][1:8];
    logic        sw_p [1:8][1:8];

    for (genvar gd = 1; gd <= 8; gd++) begin : g_d
        for (genvar gs = 1; gs <= 8; gs++) begin : g_s
            r16_pipe_delay_bank_if #(.P_WIDTH(16)) sif ();
            assign sif.stall = stall;
            assign sif.flush = flush;
            assign sif.valid_in = vin;
            assign sif.data_in = din[15:0];
            assign sif.carry_in = cin;
            assign sif.side_in = sin[16:0];
            r16_pipe_delay_bank #(.P_WIDTH(16), .DATA_DEPTH(gd), .SIDE_DEPTH(gs), .ZERO_BUBBLE(1'b0))
                u (.clk(clk), .rst_n(rst_n), .bus(sif));
            assign sw_d[gd][gs] = {sif.valid_out, sif.carry_out, sif.data_out};
            assign sw_s[gd][gs] = {sif.side_valid_out, sif.side_out};
            assign sw_p[gd][gs] = sif.primed;
        end
    end

    typedef struct {
        logic        st, fl, v, c;
        logic [63:0] d;
        logic [64:0] s;
        logic        ev, ec;
        logic [63:0] ed;
        logic        esv;
        logic [64:0] es;
        logic        ep;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic adv(input logic st, input logic fl, input logic v, input logic c,
                       input logic [63:0] d, input logic [64:0] s);
        stall = st; flush = fl; vin = v; cin = c; din = d; sin = s;
        @(posedge clk);
        @(negedge clk);
    endtask

    localparam logic [64:0] S0 = 65'h1_0000_0000_0000_0002;
    localparam logic [64:0] SB = 65'h1_0000_0000_0000_BEEF;

    logic [17:0] hd [16];
    logic [17:0] hs [16];
    logic [17:0] ed, es;
    logic        ep;
    int          n;

    initial begin
        // st fl v c d s | ev ec ed esv es ep   (default bank: data 1, side 2)
        vt[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 64'h1111, S0,     1'b1, 1'b0, 64'h1111, 1'b0, 65'h0, 1'b0};
        vt[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 64'h2222, 65'h3,  1'b1, 1'b1, 64'h2222, 1'b1, S0,    1'b1};
        vt[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 64'hDEAD, 65'h5,  1'b0, 1'b1, 64'hDEAD, 1'b1, 65'h3, 1'b1};
        vt[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 64'h9999, 65'h7,  1'b0, 1'b1, 64'hDEAD, 1'b1, 65'h3, 1'b1};
        vt[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 64'h9999, 65'h7,  1'b0, 1'b1, 64'hDEAD, 1'b1, 65'h3, 1'b1};
        vt[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 64'h4444, 65'h9,  1'b1, 1'b0, 64'h4444, 1'b0, 65'h5, 1'b1};
        vt[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 64'h5555, 65'hB,  1'b0, 1'b0, 64'h0,    1'b0, 65'h0, 1'b0};
        vt[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 64'h6666, 65'hD,  1'b1, 1'b1, 64'h6666, 1'b0, 65'h0, 1'b0};
        vt[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 64'h7777, 65'hF,  1'b1, 1'b0, 64'h7777, 1'b1, 65'hD, 1'b1};

        repeat (2) @(negedge clk);
        chk("rst_dout", if_def.data_out, 0);
        chk("rst_cout", if_def.carry_out, 0);
        chk("rst_vout", if_def.valid_out, 0);
        chk("rst_sout", if_def.side_out, 0);
        chk("rst_svout", if_def.side_valid_out, 0);
        chk("rst_primed", if_def.primed, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            adv(vt[i].st, vt[i].fl, vt[i].v, vt[i].c, vt[i].d, vt[i].s);
            chk($sformatf("v%0d_vout", i), if_def.valid_out, vt[i].ev);
            chk($sformatf("v%0d_cout", i), if_def.carry_out, vt[i].ec);
            chk($sformatf("v%0d_dout", i), if_def.data_out, vt[i].ed);
            chk($sformatf("v%0d_svout", i), if_def.side_valid_out, vt[i].esv);
            chk($sformatf("v%0d_sout", i), if_def.side_out, vt[i].es);
            chk($sformatf("v%0d_primed", i), if_def.primed, vt[i].ep);
        end

        // Stream 1,2,3,4 with a 3-cycle stall after word 2; word 3 is held upstream.
        adv(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 65'h0);
        adv(1'b0, 1'b0, 1'b1, 1'b0, 64'd1, 65'd101);
        adv(1'b0, 1'b0, 1'b1, 1'b0, 64'd2, 65'd102);
        for (int i = 0; i < 3; i++) begin
            adv(1'b1, 1'b0, 1'b1, 1'b0, 64'd3, 65'd103);
            chk("stall_dout", if_def.data_out, 64'd2);
            chk("stall_sout", if_def.side_out, 65'd101);
            chk("stall_primed", if_def.primed, 1);
        end
        adv(1'b0, 1'b0, 1'b1, 1'b0, 64'd3, 65'd103);
        chk("resume_dout3", if_def.data_out, 64'd3);
        chk("resume_sout2", if_def.side_out, 65'd102);
        adv(1'b0, 1'b0, 1'b1, 1'b0, 64'd4, 65'd104);
        chk("resume_dout4", if_def.data_out, 64'd4);
        chk("resume_sout3", if_def.side_out, 65'd103);

        // Asynchronous reset between edges with nonzero inputs.
        stall = 1'b0; flush = 1'b0; vin = 1'b1; cin = 1'b1; din = 64'hABCD; sin = 65'h1234;
        rst_n = 1'b0;
        #1;
        chk("arst_dout", if_def.data_out, 0);
        chk("arst_vout", if_def.valid_out, 0);
        chk("arst_cout", if_def.carry_out, 0);
        chk("arst_sout", if_def.side_out, 0);
        chk("arst_primed", if_def.primed, 0);
        chk("arst_fl_primed", if_fl.primed, 0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_dout", if_def.data_out, 64'hABCD);
        chk("post_rst_vout", if_def.valid_out, 1);
        chk("post_rst_primed", if_def.primed, 0);

        // Flush under stall on the 4/6 zero-bubble bank, then refill with one word and bubbles.
        for (int i = 1; i <= 5; i++) adv(1'b0, 1'b0, 1'b1, 1'b1, 64'(i), 65'(i));
        adv(1'b1, 1'b1, 1'b1, 1'b1, 64'h77, 65'h77);
        chk("flush_dout", if_fl.data_out, 0);
        chk("flush_cout", if_fl.carry_out, 0);
        chk("flush_vout", if_fl.valid_out, 0);
        chk("flush_sout", if_fl.side_out, 0);
        chk("flush_svout", if_fl.side_valid_out, 0);
        chk("flush_primed", if_fl.primed, 0);
        adv(1'b0, 1'b0, 1'b1, 1'b1, 64'hBEEF, SB);
        for (int a = 2; a <= 6; a++) begin
            adv(1'b0, 1'b0, 1'b0, 1'b1, 64'hDEAD, 65'hDEAD);
            if (a == 3) chk("fl_a3_vout", if_fl.valid_out, 0);
            if (a == 4) begin
                chk("fl_a4_vout", if_fl.valid_out, 1);
                chk("fl_a4_dout", if_fl.data_out, 64'hBEEF);
                chk("fl_a4_cout", if_fl.carry_out, 1);
            end
            if (a == 5) begin
                chk("zb1_dout", if_fl.data_out, 0);
                chk("zb1_cout", if_fl.carry_out, 0);
                chk("zb1_vout", if_fl.valid_out, 0);
                chk("fl_a5_primed", if_fl.primed, 0);
                chk("zb0_dout", if_def.data_out, 64'hDEAD);
                chk("zb0_cout", if_def.carry_out, 1);
                chk("zb0_vout", if_def.valid_out, 0);
            end
            if (a == 6) begin
                chk("fl_a6_primed", if_fl.primed, 1);
                chk("fl_a6_svout", if_fl.side_valid_out, 1);
                chk("fl_a6_sout", if_fl.side_out, SB);
            end
        end

        // Depth sweep against ideal delay lines indexed by advance count since clear.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            stall = ($urandom_range(3) == 0);
            flush = ($urandom_range(199) == 0);
            vin   = $urandom_range(1) == 1;
            cin   = $urandom_range(1) == 1;
            din   = {$urandom, $urandom};
            sin   = {1'($urandom_range(1)), $urandom, $urandom};
            @(posedge clk);
            if (flush) n = 0;
            else if (!stall) begin
                hd[n % 16] = {vin, cin, din[15:0]};
                hs[n % 16] = {vin, sin[16:0]};
                n++;
            end
            @(negedge clk);
            for (int d = 1; d <= 8; d++) begin
                for (int s = 1; s <= 8; s++) begin
                    ed = (n >= d) ? hd[(n - d) % 16] : 18'h0;
                    es = (n >= s) ? hs[(n - s) % 16] : 18'h0;
                    ep = (n >= ((d > s) ? d : s));
                    total++;
                    if ({sw_d[d][s], sw_s[d][s], sw_p[d][s]} !== {ed, es, ep}) begin
                        bad++;
                        $display("FAIL sweep d=%0d s=%0d cyc=%0d got %h want %h", d, s, cyc,
                                 {sw_d[d][s], sw_s[d][s], sw_p[d][s]}, {ed, es, ep});
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
